// File: rtl/fir_channel_scheduler_pkg.sv
// Shared state encoding and width helpers for the FIR channel scheduler.
package fir_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

    // Channel-index width; a single channel still needs one select bit.
    function automatic int calc_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Coefficient-address width for a FIR_size-tap pass.
    function automatic int calc_addr_w(input int fir_size);
        return (fir_size > 1) ? $clog2(fir_size) : 1;
    endfunction

endpackage

// File: rtl/fir_channel_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: request vector + pointer -> one-hot grant.
// With FIR_SCHED_CH0_PRIO_EN defined, channel 0 wins outright and the rest rotate.
module fir_rr_arbiter
    import fir_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = calc_ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   rr_ptr,
    output logic [NUM_CH-1:0] grant_oh,
    output logic [CH_W-1:0]   grant_idx,
    output logic              any_grant
);
    logic [NUM_CH-1:0] req_m_s;
    logic [CH_W-1:0]   cand_s;
    logic              take_s;

    // Scan channels starting at rr_ptr; the first requester found wins.
    always_comb begin
        req_m_s   = req;
        grant_oh  = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand_s    = '0;
        take_s    = 1'b0;
`ifdef FIR_SCHED_CH0_PRIO_EN
        req_m_s[0] = 1'b0;
        if (req[0]) begin
            grant_oh[0] = 1'b1;
            any_grant   = 1'b1;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                cand_s              = CH_W'((int'(rr_ptr) + k) % NUM_CH);
                take_s              = !any_grant && req_m_s[cand_s];
                grant_oh[cand_s]    = grant_oh[cand_s] | take_s;
                grant_idx           = take_s ? cand_s : grant_idx;
                any_grant           = any_grant | take_s;
            end
        end
`else
        for (int k = 0; k < NUM_CH; k++) begin
            cand_s              = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            take_s              = !any_grant && req_m_s[cand_s];
            grant_oh[cand_s]    = grant_oh[cand_s] | take_s;
            grant_idx           = take_s ? cand_s : grant_idx;
            any_grant           = any_grant | take_s;
        end
`endif
    end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Shares one single-MAC FIR datapath between NUM_CH sample streams, one pass per sample.
// Optional build macro FIR_SCHED_CH0_PRIO_EN gives channel 0 strict priority.
module fir_channel_scheduler
    import fir_sched_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  InputWidth  = 16,
    parameter int  OutputWidth = 38,
    parameter int  FIR_size    = 64,
    localparam int CH_W        = calc_ch_w(NUM_CH),
    localparam int ADDR_W      = calc_addr_w(FIR_size)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH*InputWidth-1:0] ch_data,
    output logic [NUM_CH-1:0]            ch_ready,
    output logic                         dp_shift_en,
    output logic [InputWidth-1:0]        dp_sample,
    output logic [CH_W-1:0]              dp_ch_sel,
    output logic                         dp_acc_clr,
    output logic                         dp_mac_en,
    output logic [ADDR_W-1:0]            dp_coef_addr,
    input  logic [OutputWidth-1:0]       dp_acc,
    output logic                         out_valid,
    output logic [CH_W-1:0]              out_ch,
    output logic [OutputWidth-1:0]       out_data
);
    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(FIR_size - 1);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);

    sched_state_t            state_r;
    sched_state_t            state_next_s;
    logic [ADDR_W-1:0]       cnt_r;
    logic [ADDR_W-1:0]       cnt_next_s;
    logic [CH_W-1:0]         rr_ptr_r;
    logic [CH_W-1:0]         rr_next_s;
    logic [CH_W-1:0]         ch_sel_r;
    logic [InputWidth-1:0]   sample_r;
    logic                    shift_en_r;
    logic                    acc_clr_r;
    logic                    mac_en_r;
    logic                    out_valid_r;
    logic [CH_W-1:0]         out_ch_r;
    logic [OutputWidth-1:0]  out_data_r;

    logic [NUM_CH-1:0]       grant_oh_s;
    logic [CH_W-1:0]         grant_idx_s;
    logic                    any_grant_s;
    logic                    transfer_s;
    logic [InputWidth-1:0]   grant_sample_s;

    fir_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req       (ch_valid),
        .rr_ptr    (rr_ptr_r),
        .grant_oh  (grant_oh_s),
        .grant_idx (grant_idx_s),
        .any_grant (any_grant_s)
    );

    // Accept only in IDLE and never while reset is held.
    always_comb begin
        transfer_s = 1'b0;
        ch_ready   = '0;
        if (rst && (state_r == IDLE) && any_grant_s) begin
            transfer_s = 1'b1;
            ch_ready   = grant_oh_s;
        end else begin
            transfer_s = 1'b0;
            ch_ready   = '0;
        end
    end

    // Select the granted channel's sample by masking each lane with its grant bit.
    always_comb begin
        grant_sample_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            grant_sample_s = grant_sample_s
                           | (ch_data[k*InputWidth +: InputWidth] & {InputWidth{grant_oh_s[k]}});
        end
    end

    // Next-state and tap-counter logic for one shift/MAC/drain pass.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = '0;
        case (state_r)
            IDLE: begin
                if (transfer_s) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD:  state_next_s = MAC;
            MAC: begin
                if (cnt_r == LAST_TAP) begin
                    state_next_s = DRAIN;
                    cnt_next_s   = '0;
                end else begin
                    state_next_s = MAC;
                    cnt_next_s   = cnt_r + ADDR_W'(1);
                end
            end
            DRAIN: state_next_s = DONE;
            DONE:  state_next_s = IDLE;
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // Pointer value that follows the channel currently being served.
    always_comb begin
        rr_next_s = '0;
        if (ch_sel_r == LAST_CH) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = ch_sel_r + CH_W'(1);
        end
    end

    // State register and tap counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Datapath strobes registered from next state so they change only on clock edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_en_r  <= 1'b0;
            acc_clr_r   <= 1'b0;
            mac_en_r    <= 1'b0;
            out_valid_r <= 1'b0;
            sample_r    <= '0;
        end else begin
            shift_en_r  <= (state_next_s == LOAD);
            acc_clr_r   <= (state_next_s == LOAD);
            mac_en_r    <= (state_next_s == MAC);
            out_valid_r <= (state_next_s == DONE);
            sample_r    <= transfer_s ? grant_sample_s : '0;
        end
    end

    // Channel bank select: held from LOAD through DONE, zero while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_sel_r <= '0;
        end else if (transfer_s) begin
            ch_sel_r <= grant_idx_s;
        end else if (state_r == DONE) begin
            ch_sel_r <= '0;
        end else begin
            ch_sel_r <= ch_sel_r;
        end
    end

    // The accumulator is final once DRAIN is reached; capture it for the DONE strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_ch_r   <= '0;
            out_data_r <= '0;
        end else if (state_r == DRAIN) begin
            out_ch_r   <= ch_sel_r;
            out_data_r <= dp_acc;
        end else begin
            out_ch_r   <= out_ch_r;
            out_data_r <= out_data_r;
        end
    end

    // Round-robin pointer advances past the served channel at the end of each pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r <= '0;
        end else if (state_r == DONE) begin
`ifdef FIR_SCHED_CH0_PRIO_EN
            if (ch_sel_r != '0) begin
                rr_ptr_r <= rr_next_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
`else
            rr_ptr_r <= rr_next_s;
`endif
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign dp_shift_en  = shift_en_r;
    assign dp_acc_clr   = acc_clr_r;
    assign dp_mac_en    = mac_en_r;
    assign dp_sample    = sample_r;
    assign dp_ch_sel    = ch_sel_r;
    assign dp_coef_addr = cnt_r;
    assign out_valid    = out_valid_r;
    assign out_ch       = out_ch_r;
    assign out_data     = out_data_r;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench for fir_channel_scheduler with a behavioural single-MAC datapath (coef[a] = a+1).
module tb_fir_channel_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  ch_valid = 4'd0;
    logic [63:0] ch_data = 64'd0;
    logic [3:0]  ch_ready;
    logic        dp_shift_en;
    logic [15:0] dp_sample;
    logic [1:0]  dp_ch_sel;
    logic        dp_acc_clr;
    logic        dp_mac_en;
    logic [5:0]  dp_coef_addr;
    logic [37:0] dp_acc;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [37:0] out_data;

    int checks = 0;
    int failures = 0;

    fir_channel_scheduler #(
        .NUM_CH(4), .InputWidth(16), .OutputWidth(38), .FIR_size(64)
    ) dut (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
        .dp_shift_en(dp_shift_en), .dp_sample(dp_sample), .dp_ch_sel(dp_ch_sel),
        .dp_acc_clr(dp_acc_clr), .dp_mac_en(dp_mac_en), .dp_coef_addr(dp_coef_addr),
        .dp_acc(dp_acc), .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: per-channel delay lines, accumulator with one register stage.
    logic [15:0] dl [4][64] = '{default: '0};
    logic [37:0] acc = 38'd0;
    always @(posedge clk) begin
        if (dp_shift_en) begin
            for (int i = 63; i > 0; i--) dl[dp_ch_sel][i] <= dl[dp_ch_sel][i-1];
            dl[dp_ch_sel][0] <= dp_sample;
        end
        if (dp_acc_clr) acc <= 38'd0;
        else if (dp_mac_en) acc <= acc + 38'(dp_coef_addr + 1) * 38'(dl[dp_ch_sel][dp_coef_addr]);
    end
    assign dp_acc = acc;

    // Protocol monitors; their error counters are checked at the end of the run.
    int cyc = 0, onehot_err = 0, mac_err = 0, addr_err = 0, ov_err = 0;
    int ready1_cnt = 0, ov_cnt = 0, mac_cnt = 0;
    logic mac_h1 = 1'b0, mac_h2 = 1'b0;
    logic [5:0] prev_addr = 6'd0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!$onehot0(ch_ready)) onehot_err <= onehot_err + 1;
        if (ch_ready[1]) ready1_cnt <= ready1_cnt + 1;
        if (out_valid) begin
            ov_cnt <= ov_cnt + 1;
            if (mac_cnt != 64) mac_err <= mac_err + 1;
            if (!(mac_h2 && !mac_h1)) ov_err <= ov_err + 1;
        end
        if (dp_acc_clr) mac_cnt <= 0;
        else if (dp_mac_en) mac_cnt <= mac_cnt + 1;
        if (dp_mac_en && (dp_coef_addr !== (mac_h1 ? 6'(prev_addr + 6'd1) : 6'd0)))
            addr_err <= addr_err + 1;
        mac_h1 <= dp_mac_en;
        mac_h2 <= mac_h1;
        prev_addr <= dp_coef_addr;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait for the next accept, check which channel got ready, then move into LOAD.
    task automatic wait_grant(input string tag, input logic [3:0] exp_ready);
        int n;
        n = 0;
        #1;
        while (((ch_ready & ch_valid) == 4'd0) && (n < 400)) begin
            step(1);
            n++;
        end
        chk({tag, "_ready"}, 64'(ch_ready), 64'(exp_ready));
        step(1);
    endtask

    // Wait for the next result strobe, check its channel, then step past it.
    task automatic wait_out(input string tag, input logic [1:0] exp_ch, output int at);
        int n;
        n = 0;
        while ((out_valid !== 1'b1) && (n < 400)) begin
            step(1);
            n++;
        end
        chk({tag, "_seen"}, 64'(out_valid), 64'd1);
        chk({tag, "_ch"}, 64'(out_ch), 64'(exp_ch));
        at = cyc;
        step(1);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    initial begin
        int mac_bad;
        int at;
        int t2 [5];
        int ov0, r0;
        logic [1:0] seq3 [4];

        // Reset state: requests present but nothing accepted, all outputs cleared.
        ch_valid = 4'hF;
        step(3);
        chk("rst_ready", 64'(ch_ready), 64'd0);
        chk("rst_strobes", 64'({dp_shift_en, dp_acc_clr, dp_mac_en, out_valid, dp_coef_addr, dp_ch_sel, out_ch}), 64'd0);
        chk("rst_data", 64'({dp_sample, out_data}), 64'd0);
        ch_valid = 4'd0;
        rst = 1'b1;
        step(1);

        // 1: single request on ch2, cycle-accurate timing.
        ch_data = {16'h0000, 16'h0001, 16'h0000, 16'h0000};
        ch_valid = 4'b0100;
        #1;
        chk("t1_ready", 64'(ch_ready), 64'b0100);
        step(1);
        ch_valid = 4'd0;
        chk("t1_load_strobes", 64'({dp_shift_en, dp_acc_clr, dp_mac_en}), 64'b110);
        chk("t1_load_sample", 64'(dp_sample), 64'h0001);
        chk("t1_load_sel", 64'(dp_ch_sel), 64'd2);
        mac_bad = 0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            if ((dp_mac_en !== 1'b1) || (dp_coef_addr !== 6'(i)) || (dp_ch_sel !== 2'd2)) mac_bad++;
        end
        chk("t1_mac_steps", 64'(mac_bad), 64'd0);
        step(1);
        chk("t1_drain", 64'({dp_mac_en, out_valid, dp_shift_en}), 64'd0);
        step(1);
        chk("t1_done_valid", 64'(out_valid), 64'd1);
        chk("t1_done_ch", 64'(out_ch), 64'd2);
        chk("t1_done_data", 64'(out_data), 64'd1);
        step(1);
        chk("t1_after_valid", 64'(out_valid), 64'd0);
        chk("t1_hold_data", 64'(out_data), 64'd1);
        chk("t1_idle_sel", 64'(dp_ch_sel), 64'd0);

        // 1b: second ch2 sample; delay line [FFFF,1] -> 1*FFFF + 2*1.
        ch_data = {16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        ch_valid = 4'b0100;
        wait_grant("t1b", 4'b0100);
        ch_valid = 4'd0;
        wait_out("t1b", 2'd2, at);
        chk("t1b_data", 64'(out_data), 64'h10001);

        // 2: all channels requesting from reset -> 0,1,2,3,0 one result per 68 cycles.
        ch_data = {16'd4, 16'd3, 16'd2, 16'd1};
        ch_valid = 4'hF;
        pulse_reset();
        wait_out("t2_0", 2'd0, t2[0]);
        wait_out("t2_1", 2'd1, t2[1]);
        wait_out("t2_2", 2'd2, t2[2]);
        wait_out("t2_3", 2'd3, t2[3]);
        wait_out("t2_4", 2'd0, t2[4]);
        ch_valid = 4'd0;
        for (int k = 1; k < 5; k++) chk("t2_period", 64'(t2[k] - t2[k-1]), 64'd68);

        // 3: ch0 and ch3 requesting with rr_ptr=1 -> 3,0,3,0.
        pulse_reset();
        ch_valid = 4'b0001;
        wait_grant("t3_setup", 4'b0001);
        ch_valid = 4'd0;
        wait_out("t3_setup", 2'd0, at);
        ch_valid = 4'b1001;
        seq3[0] = 2'd3; seq3[1] = 2'd0; seq3[2] = 2'd3; seq3[3] = 2'd0;
        for (int k = 0; k < 4; k++) wait_out("t3_seq", seq3[k], at);
        ch_valid = 4'd0;

        // 4: reset at tap 30 aborts the pass; next grant after release is ch0.
        ch_valid = 4'b0100;
        wait_grant("t4", 4'b0100);
        ch_valid = 4'd0;
        mac_bad = 0;
        while ((dp_coef_addr !== 6'd30) && (mac_bad < 100)) begin
            step(1);
            mac_bad++;
        end
        chk("t4_reach_tap30", 64'(dp_coef_addr), 64'd30);
        ov0 = ov_cnt;
        rst = 1'b0;
        #1;
        chk("t4_rst_strobes", 64'({ch_ready, dp_shift_en, dp_acc_clr, dp_mac_en, dp_coef_addr, dp_ch_sel, out_valid, out_ch}), 64'd0);
        chk("t4_rst_data", 64'({dp_sample, out_data}), 64'd0);
        ch_valid = 4'b0101;
        step(3);
        chk("t4_ready_in_rst", 64'(ch_ready), 64'd0);
        rst = 1'b1;
        wait_grant("t4_after", 4'b0001);
        ch_valid = 4'd0;
        wait_out("t4_after", 2'd0, at);
        chk("t4_one_result", 64'(ov_cnt - ov0), 64'd1);

        // 5: ch1 offers for one cycle while busy, then withdraws.
        ov0 = ov_cnt;
        r0 = ready1_cnt;
        ch_valid = 4'b0001;
        wait_grant("t5", 4'b0001);
        ch_valid = 4'd0;
        step(5);
        ch_valid = 4'b0010;
        step(1);
        ch_valid = 4'd0;
        wait_out("t5", 2'd0, at);
        step(3);
        chk("t5_no_ready1", 64'(ready1_cnt - r0), 64'd0);
        chk("t5_one_result", 64'(ov_cnt - ov0), 64'd1);
        chk("t5_idle_ready", 64'(ch_ready), 64'd0);

        // 6: all requesting with rr_ptr=2.
        pulse_reset();
        ch_valid = 4'b0010;
        wait_grant("t6_setup", 4'b0010);
        ch_valid = 4'd0;
        wait_out("t6_setup", 2'd1, at);
        ch_valid = 4'hF;
`ifdef FIR_SCHED_CH0_PRIO_EN
        wait_out("t6_a", 2'd0, at);
        wait_out("t6_b", 2'd0, at);
        ch_valid = 4'hE;
        wait_out("t6_c", 2'd2, at);
        wait_out("t6_d", 2'd3, at);
`else
        wait_out("t6_a", 2'd2, at);
        wait_out("t6_b", 2'd3, at);
        wait_out("t6_c", 2'd0, at);
        wait_out("t6_d", 2'd1, at);
`endif
        ch_valid = 4'd0;
        step(4);

        chk("mon_onehot", 64'(onehot_err), 64'd0);
        chk("mon_mac_count", 64'(mac_err), 64'd0);
        chk("mon_addr_incr", 64'(addr_err), 64'd0);
        chk("mon_valid_in_done", 64'(ov_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
